mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, data word width.
- ADDR_W, 32, word-address width.
- RAM_WORDS, 65537, valid RAM word count; word addresses 0..RAM_WORDS-1.
- STARVE_LIMIT, 4, consecutive fetch-loss cycles before fetch is forced.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  instruction-fetch read request.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data-port request.
- d_we  in  1  data-port write (1) / read (0).
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  data write value.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response valid; pulses for reads and writes.
- d_rdata  out  DATA_W  data read data; 0 for writes.
- d_err  out  1  with d_rvalid: out-of-range access.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; combinational from ram_addr.

Function
REQ-003 At most one of if_gnt/d_gnt SHALL be high per cycle; a grant SHALL be issued only to a requester whose req is high.
REQ-004 The grant SHALL be combinational from the req inputs and registered state; the granted port's address, and for the data port its d_we and d_wdata, SHALL drive the ram_* outputs in the same cycle.
REQ-005 With no grant, ram_we SHALL be 0; ram_addr and ram_wdata SHALL hold their last values.
REQ-006 ram_rdata SHALL be registered at the grant edge; the matching rvalid SHALL be high for exactly one cycle, the cycle after the grant (latency 1).
REQ-007 Back-to-back grants SHALL be supported: one access per cycle, either port, no bubble.
REQ-008 Default arbitration SHALL be fixed priority, data over fetch.
REQ-009 A 3-bit starve counter SHALL increment each cycle if_req is high and not granted, and clear on if_gnt or when if_req is low.
REQ-010 When starve counter = STARVE_LIMIT, fetch SHALL win the next contention even over data.
REQ-011 An access with address >= RAM_WORDS SHALL be granted without driving the RAM (ram_we=0).
- Its response SHALL have rdata 0.
- d_err=1 with d_rvalid; a fetch out-of-range access SHALL return rdata 0 with no error flag.
REQ-012 Requesters SHALL hold req and payload stable until gnt; the arbiter SHALL not buffer more than one outstanding response per port.

Reset
REQ-013 While reset is high, all gnt, rvalid, d_err and ram_we SHALL be 0; rdata outputs, ram_addr, ram_wdata and the starve counter SHALL be 0; the last-winner state SHALL be set to fetch.
REQ-014 A grant in the cycle reset asserts SHALL be discarded: no rvalid follows, and no RAM write occurs.

Configuration
REQ-015 Macro MEM_ARB_ROUND_ROBIN_EN defined: under contention, the port not granted last SHALL win, and the starve counter SHALL be removed.
REQ-016 Macro undefined: REQ-008 through REQ-010 apply.

Structure
REQ-017 Package pillar_mem_pkg SHALL hold DATA_W/ADDR_W defaults, the port-select enum {PORT_IF, PORT_D}, and the response-record typedef (valid, err, rdata).
REQ-018 Sub-module mem_arb_pick SHALL implement the grant decision only: inputs = reqs, last winner, starve flag; output = one-hot grant.

Verification
REQ-019 Contention: d_req=1 d_we=1 addr 0x10 wdata 0xDEADBEEF, if_req=1 addr 0x20, same cycle -> d_gnt=1, ram_we=1; next cycle if_gnt=1; a later read of 0x10 returns 0xDEADBEEF.
REQ-020 Starvation: d_req held high, if_req high -> if_gnt rises on the 5th contended cycle (STARVE_LIMIT=4), then data resumes.
REQ-021 Back-to-back reads: fetch reads 0,1,2 on consecutive cycles -> if_rvalid high for 3 consecutive cycles, rdata = ram[0..2] in order.
REQ-022 Out-of-range write: d_addr=0x10001, write -> no RAM change, d_rvalid=1 and d_err=1 one cycle later.
REQ-023 Reset during grant: reset asserted in a write-grant cycle -> no RAM write, no rvalid; all outputs 0 the next cycle.
REQ-024 Round-robin build (MEM_ARB_ROUND_ROBIN_EN): both ports requesting continuously -> grants alternate starting with data.

Source files
------------

// File: rtl/pillar_mem_pkg.sv
// Shared widths, port-select enum and response record for the fetch/data memory arbiter.
package pillar_mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    // Response is sized by the package default data width.
    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DEF_DATA_W-1:0] rdata;
    } resp_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision for the two-port memory arbiter; purely combinational, one-hot out.
// MEM_ARB_ROUND_ROBIN_EN: contention goes to the port not granted last; otherwise data wins unless fetch is starving.
module mem_arb_pick
    import pillar_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  port_e      last_win_i,
    input  logic       starve_i,
    output logic [1:0] gnt_o
);

    port_e cont_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic unused_starve;
    assign unused_starve = starve_i;
    assign cont_win      = (last_win_i == PORT_D) ? PORT_IF : PORT_D;
`else
    logic unused_last;
    assign unused_last = last_win_i;
    assign cont_win    = starve_i ? PORT_IF : PORT_D;
`endif

    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o           = '0;
            gnt_o[cont_win] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port RAM: one access per cycle, read latency 1.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration (no starve counter).
module mem_arbiter
    import pillar_mem_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int RAM_WORDS    = 65537,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [63:0] RAM_LIM = 64'(RAM_WORDS);

    logic [1:0]        req, gnt;
    logic              gnt_if, gnt_d, sel_oor, ram_drive, starve;
    logic [ADDR_W-1:0] sel_addr, ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    port_e             last_q, last_d;
    resp_t             if_resp_q, if_resp_d, d_resp_q, d_resp_d;
    logic              unused_if_err;

    // Reset masks requests so a grant in the reset cycle never happens.
    always_comb begin
        req          = '0;
        req[PORT_IF] = if_req & ~reset;
        req[PORT_D]  = d_req & ~reset;
    end

    mem_arb_pick u_pick (
        .req_i      (req),
        .last_win_i (last_q),
        .starve_i   (starve),
        .gnt_o      (gnt)
    );

    assign gnt_if    = gnt[PORT_IF];
    assign gnt_d     = gnt[PORT_D];
    assign sel_addr  = gnt_d ? d_addr : if_addr;
    assign sel_oor   = 64'(sel_addr) >= RAM_LIM;
    assign ram_drive = (gnt_if || gnt_d) && !sel_oor;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign starve = 1'b0;
`else
    logic [2:0] starve_q, starve_d;

    always_comb begin
        starve_d = '0;
        if (if_req && !gnt_if)
            starve_d = (starve_q == 3'd7) ? starve_q : starve_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end

    assign starve = 32'(starve_q) >= STARVE_LIMIT;
`endif

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (ram_drive) begin
            ram_addr_d = sel_addr;
            if (gnt_d) ram_wdata_d = d_wdata;
        end

        if_resp_d       = '0;
        if_resp_d.valid = gnt_if;
        if_resp_d.rdata = (gnt_if && !sel_oor) ? ram_rdata : '0;

        d_resp_d        = '0;
        d_resp_d.valid  = gnt_d;
        d_resp_d.err    = gnt_d && sel_oor;
        d_resp_d.rdata  = (gnt_d && !d_we && !sel_oor) ? ram_rdata : '0;

        last_d = last_q;
        if (gnt_d)       last_d = PORT_D;
        else if (gnt_if) last_d = PORT_IF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_resp_q   <= '0;
            d_resp_q    <= '0;
            last_q      <= PORT_IF;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_resp_q   <= if_resp_d;
            d_resp_q    <= d_resp_d;
            last_q      <= last_d;
        end
    end

    assign unused_if_err = if_resp_q.err;

    assign if_gnt    = gnt_if;
    assign d_gnt     = gnt_d;
    assign ram_we    = gnt_d && d_we && !sel_oor;
    assign ram_addr  = reset ? '0 : ram_addr_d;
    assign ram_wdata = reset ? '0 : ram_wdata_d;
    assign if_rvalid = if_resp_q.valid && !reset;
    assign if_rdata  = reset ? '0 : if_resp_q.rdata;
    assign d_rvalid  = d_resp_q.valid && !reset;
    assign d_err     = d_resp_q.err && !reset;
    assign d_rdata   = reset ? '0 : d_resp_q.rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios, then random traffic against a reference model.
module tb_mem_arbiter;

    localparam int DW = 32, AW = 32, WORDS = 65537, LIM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, ram_we;
    logic [DW-1:0] if_rdata, d_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] ram     [WORDS];
    logic [DW-1:0] ref_mem [WORDS];

    int n_cmp = 0, n_bad = 0;

    // reference model state
    logic          m_last_d = 1'b0;
    int            m_starve = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          e_if_v = 1'b0, e_d_v = 1'b0, e_d_err = 1'b0;
    logic [DW-1:0] e_if_data = '0, e_d_data = '0;
    logic          m_gi, m_gd, o_ig, o_dg, o_we;

    // random requester state
    logic          p_ir = 1'b0, p_dr = 1'b0, p_dw = 1'b0, r_rst;
    logic [AW-1:0] p_ia = '0, p_da = '0;
    logic [DW-1:0] p_dd = '0;
    int            rv_cnt = 0, first = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    assign ram_rdata = (ram_addr < 32'(WORDS)) ? ram[ram_addr] : 32'hBAD0_BAD0;

    always @(posedge clk)
        if (ram_we && ram_addr < 32'(WORDS)) ram[ram_addr] <= ram_wdata;

    function automatic logic [DW-1:0] pat(input int i);
        return 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h0001_0000;
            1:       return 32'h0001_0001;
            2:       return $urandom();
            default: return 32'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check combinational and registered outputs, advance model at posedge.
    task automatic step(input logic rst, input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        logic          gi, gd, oor;
        logic [AW-1:0] a, ea;
        logic [DW-1:0] ew;
        @(negedge clk);
        reset = rst; if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #1;
        gi = 1'b0; gd = 1'b0;
        if (!rst) begin
            if (ir && dr) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                gi = m_last_d;
`else
                gi = (m_starve >= LIM);
`endif
                gd = !gi;
            end else begin
                gi = ir; gd = dr;
            end
        end
        a   = gd ? da : ia;
        oor = {32'd0, a} >= 64'(WORDS);
        ea  = rst ? '0 : (((gi || gd) && !oor) ? a : m_addr);
        ew  = rst ? '0 : ((gd && !oor) ? dd : m_wdata);
        m_gi = gi; m_gd = gd;
        o_ig = if_gnt; o_dg = d_gnt; o_we = ram_we;
        chk("if_gnt", if_gnt, gi);
        chk("d_gnt", d_gnt, gd);
        chk("ram_we", ram_we, gd && dw && !oor);
        chk("ram_addr", ram_addr, ea);
        chk("ram_wdata", ram_wdata, ew);
        chk("if_rvalid", if_rvalid, !rst && e_if_v);
        chk("if_rdata", if_rdata, rst ? '0 : e_if_data);
        chk("d_rvalid", d_rvalid, !rst && e_d_v);
        chk("d_err", d_err, !rst && e_d_err);
        chk("d_rdata", d_rdata, rst ? '0 : e_d_data);
        @(posedge clk);
        if (rst) begin
            m_last_d = 1'b0; m_starve = 0; m_addr = '0; m_wdata = '0;
            e_if_v = 1'b0; e_d_v = 1'b0; e_d_err = 1'b0; e_if_data = '0; e_d_data = '0;
        end else begin
            e_if_v    = gi;
            e_if_data = (gi && !oor) ? ref_mem[a] : '0;
            e_d_v     = gd;
            e_d_err   = gd && oor;
            e_d_data  = (gd && !dw && !oor) ? ref_mem[a] : '0;
            if (gd && dw && !oor) ref_mem[a] = dd;
            if (gi || gd) m_last_d = gd;
            m_addr   = ea;
            m_wdata  = ew;
            m_starve = (ir && !gi) ? ((m_starve < 7) ? m_starve + 1 : 7) : 0;
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram[i]    <= pat(i);
            ref_mem[i] = pat(i);
        end

        // reset with a write pending: the grant is discarded
        step(1, 1, 32'h20, 1, 1, 32'h31, 32'h1234_5678);
        chk("rst_no_we", o_we, 1'b0);
        step(1, 0, '0, 0, 0, '0, '0);
        step(0, 0, '0, 0, 0, '0, '0);

        // contention: data write first, fetch next cycle, then readback
        step(0, 1, 32'h20, 1, 1, 32'h10, 32'hDEAD_BEEF);
        chk("cont_dgnt", o_dg, 1'b1);
        chk("cont_we", o_we, 1'b1);
        step(0, 1, 32'h20, 0, 0, '0, '0);
        chk("cont_ifgnt", o_ig, 1'b1);
        step(0, 0, '0, 1, 0, 32'h10, '0);
        #1 chk("rd_10", d_rdata, 32'hDEAD_BEEF);
        step(0, 0, '0, 1, 0, 32'h31, '0);
        #1 chk("rd_31_after_rst", d_rdata, pat(32'h31));

        // out-of-range write
        step(0, 0, '0, 1, 1, 32'h0001_0001, 32'hA5A5_A5A5);
        chk("oor_we", o_we, 1'b0);
        #1;
        chk("oor_rvalid", d_rvalid, 1'b1);
        chk("oor_err", d_err, 1'b1);
        step(0, 0, '0, 1, 0, 32'h1, '0);
        #1 chk("oor_nochg", d_rdata, pat(1));

        // back-to-back fetch reads
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 32'(k), 0, 0, '0, '0);
            #1 if (if_rvalid && if_rdata == pat(k)) rv_cnt++;
        end
        step(0, 0, '0, 0, 0, '0, '0);
        chk("b2b_if", rv_cnt, 3);

        // starvation: data requesting every cycle
        for (int k = 1; k <= 8 && first == 0; k++) begin
            step(0, 1, 32'h5, 1, 0, 32'(k), '0);
            if (o_ig) first = k;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("starve_cycle", first, 2);
`else
        chk("starve_cycle", first, LIM + 1);
`endif
        step(0, 1, 32'h6, 1, 0, 32'h7, '0);
        chk("d_resume", o_dg, 1'b1);
        step(0, 0, '0, 0, 0, '0, '0);

        // random traffic; requesters hold payload until granted
        for (int i = 0; i < 3000; i++) begin
            if (!p_ir && $urandom_range(0, 2) != 0) begin
                p_ir = 1'b1; p_ia = rnd_addr();
            end
            if (!p_dr && $urandom_range(0, 2) != 0) begin
                p_dr = 1'b1; p_dw = 1'($urandom_range(0, 1)); p_da = rnd_addr(); p_dd = $urandom();
            end
            r_rst = ($urandom_range(0, 59) == 0);
            step(r_rst, p_ir, p_ia, p_dr, p_dw, p_da, p_dd);
            if (m_gi) p_ir = 1'b0;
            if (m_gd) p_dr = 1'b0;
        end
        step(0, 0, '0, 0, 0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
